trial_sequencer: RTL

TRIAL_SEQUENCER -- requirements
Module: trial_sequencer

---
 rtl/trial_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/trial_sequencer.sv
// Purpose: reaction-time trial sequencer; random arm delay, lamp, timed response, session stats.
// Latency: recorded time visible on last_ms the cycle after REACT exit; avg_ms registered on DONE entry.
// Backpressure: none; button edges outside their accepting states are dropped.
// Ports: clk/reset (async active-low); start/stop button levels; tick_ms 1 ms strobe;
//        rand_delay random source; led lamp; state_code/trial_idx status; last/best/avg_ms results;
//        session_done high in DONE.
module trial_sequencer #(
   parameter int NUM_TRIALS = 4,
   parameter int TIMEOUT_MS = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       tick_ms,
   input  logic [3:0] rand_delay,
   output logic       led,
   output logic [2:0] state_code,
   output logic [2:0] trial_idx,
   output logic [9:0] last_ms,
   output logic [9:0] best_ms,
   output logic [9:0] avg_ms,
   output logic       session_done
);

   localparam int          LOG2N      = $clog2(NUM_TRIALS);
   localparam logic [2:0]  LAST_IDX   = 3'(NUM_TRIALS - 1);
   localparam logic [13:0] TMO_CNT    = 14'(TIMEOUT_MS);
   localparam logic [9:0]  TMO_REC    = 10'(TIMEOUT_MS);
   localparam logic [9:0]  BEST_EMPTY = 10'd1023;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_REACT  = 3'd2,
      S_RESULT = 3'd3,
      S_FAULT  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t      state, state_nxt;
   logic        start_q, stop_q, hist_vld;
   logic [13:0] cnt, cnt_nxt;
   logic [13:0] target, target_nxt;
   logic [2:0]  idx_nxt;
   logic [9:0]  last_nxt, best_nxt, avg_nxt;
   logic [12:0] sum, sum_nxt;

   logic        start_edge, stop_edge;
   logic [3:0]  delay_sel;
   logic [13:0] target_calc;
   logic [13:0] cnt_inc;
   logic        rec_en;
   logic [9:0]  rec_val;

   // hist_vld stays low for the first cycle after reset release so that a
   // button already held high at release is not mistaken for a press.
   assign start_edge  = start & ~start_q & hist_vld;
   assign stop_edge   = stop & ~stop_q & hist_vld;

   assign delay_sel   = (rand_delay < 4'd2) ? 4'd2 : rand_delay;
   assign target_calc = {10'd0, delay_sel} * 14'd1000;
   assign cnt_inc     = cnt + 14'd1;

   assign state_code   = state;
   assign led          = (state == S_REACT);
   assign session_done = (state == S_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         hist_vld  <= 1'b0;
         cnt       <= '0;
         target    <= '0;
         trial_idx <= '0;
         last_ms   <= '0;
         best_ms   <= BEST_EMPTY;
         avg_ms    <= '0;
         sum       <= '0;
      end else begin
         state     <= state_nxt;
         start_q   <= start;
         stop_q    <= stop;
         hist_vld  <= 1'b1;
         cnt       <= cnt_nxt;
         target    <= target_nxt;
         trial_idx <= idx_nxt;
         last_ms   <= last_nxt;
         best_ms   <= best_nxt;
         avg_ms    <= avg_nxt;
         sum       <= sum_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      target_nxt = target;
      idx_nxt    = trial_idx;
      last_nxt   = last_ms;
      best_nxt   = best_ms;
      avg_nxt    = avg_ms;
      sum_nxt    = sum;
      rec_en     = 1'b0;
      rec_val    = '0;

      case (state)
         S_IDLE, S_DONE: begin
            if (start_edge) begin
               state_nxt  = S_ARM;
               target_nxt = target_calc;
               cnt_nxt    = '0;
               sum_nxt    = '0;
               best_nxt   = BEST_EMPTY;
               last_nxt   = '0;
               idx_nxt    = '0;
            end
         end
         S_ARM: begin
            // Stop beats a coinciding target tick: early press is a fault.
            if (stop_edge) begin
               state_nxt = S_FAULT;
            end else if (tick_ms) begin
               if (cnt_inc == target) begin
                  cnt_nxt   = '0;
                  state_nxt = S_REACT;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
         end
         S_REACT: begin
            // A stop coinciding with a tick records the pre-increment count.
            if (stop_edge) begin
               rec_en    = 1'b1;
               rec_val   = cnt[9:0];
               state_nxt = S_RESULT;
            end else if (tick_ms) begin
               if (cnt_inc == TMO_CNT) begin
                  rec_en    = 1'b1;
                  rec_val   = TMO_REC;
                  state_nxt = S_RESULT;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
         end
         S_RESULT: begin
            if (start_edge) begin
               if (trial_idx == LAST_IDX) begin
                  state_nxt = S_DONE;
                  avg_nxt   = 10'(sum >> LOG2N);
               end else begin
                  idx_nxt    = trial_idx + 3'd1;
                  target_nxt = target_calc;
                  cnt_nxt    = '0;
                  state_nxt  = S_ARM;
               end
            end
         end
         S_FAULT: begin
            if (start_edge) begin
               target_nxt = target_calc;
               cnt_nxt    = '0;
               state_nxt  = S_ARM;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      if (rec_en) begin
         last_nxt = rec_val;
         sum_nxt  = sum + {3'd0, rec_val};
         best_nxt = (rec_val < best_ms) ? rec_val : best_ms;
      end
   end

endmodule
